// File: rtl/pmem_arbiter.sv
// Arbitrates I-cache fills and D-cache fills/writebacks onto a single cacheline adaptor.
// Address and write data are captured at grant and held until the adaptor responds.
module pmem_arbiter #(
    parameter int unsigned LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [31:0]       i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [31:0]       d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp,
    output logic [15:0]       i_grants,
    output logic [15:0]       d_grants
);

    typedef enum logic [1:0] {IDLE, I_RD, D_RD, D_WR} state_t;

    state_t state;
    logic   last_grant_d;
    logic   d_req;
    logic   grant_d;

    // Under contention the side opposite the last grant wins.
    assign d_req   = d_read | d_write;
    assign grant_d = d_req & (~i_read | ~last_grant_d);

    // Responses are routed without delay; reset suppresses any in-flight response.
    assign i_resp  = ~rst & mem_resp & (state == I_RD);
    assign d_resp  = ~rst & mem_resp & ((state == D_RD) | (state == D_WR));
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last_grant_d <= 1'b0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            mem_address  <= '0;
            mem_wdata    <= '0;
            i_grants     <= '0;
            d_grants     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state        <= d_write ? D_WR : D_RD;
                        mem_read     <= ~d_write;
                        mem_write    <= d_write;
                        mem_address  <= d_address;
                        if (d_write) begin
                            mem_wdata <= d_wdata;
                        end
                        last_grant_d <= 1'b1;
                        d_grants     <= d_grants + 16'd1;
                    end else if (i_read) begin
                        state        <= I_RD;
                        mem_read     <= 1'b1;
                        mem_write    <= 1'b0;
                        mem_address  <= i_address;
                        last_grant_d <= 1'b0;
                        i_grants     <= i_grants + 16'd1;
                    end
                end
                default: begin
                    // Busy: requester inputs are ignored until the adaptor completes.
                    if (mem_resp) begin
                        state     <= IDLE;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter: directed vector table, corner sequences, random traffic vs model.
module tb_pmem_arbiter;

    localparam int unsigned LINE_W = 256;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_read, d_read, d_write, mem_resp;
    logic [31:0]       i_address, d_address;
    logic [LINE_W-1:0] d_wdata, mem_rdata;
    logic [LINE_W-1:0] i_rdata, d_rdata, mem_wdata;
    logic              i_resp, d_resp, mem_read, mem_write;
    logic [31:0]       mem_address;
    logic [15:0]       i_grants, d_grants;

    int n_tests = 0;
    int n_fail  = 0;

    // Transaction-level reference: who owns the adaptor and what was captured.
    bit                m_busy;
    bit                m_owner_d;
    bit                m_is_write;
    logic [31:0]       m_addr;
    logic [LINE_W-1:0] m_wdata;
    bit                m_last_was_d;
    logic [15:0]       m_icnt, m_dcnt;

    pmem_arbiter #(.LINE_W(LINE_W)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .i_grants(i_grants), .d_grants(d_grants)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, ir, dr, dw, mr;
        logic [31:0] ia, da;
        logic        e_mrd, e_mwr, e_iresp, e_dresp;
        logic [31:0] e_addr;
    } vec_t;

    task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, ir, dr, dw, mr, input logic [31:0] ia, da,
                         input logic [LINE_W-1:0] wd, rd);
        @(negedge clk);
        rst = r; i_read = ir; d_read = dr; d_write = dw; mem_resp = mr;
        i_address = ia; d_address = da; d_wdata = wd; mem_rdata = rd;
        #1;
    endtask

    task automatic check_model();
        chk("mem_read",    LINE_W'(mem_read),    LINE_W'(m_busy && !m_is_write));
        chk("mem_write",   LINE_W'(mem_write),   LINE_W'(m_busy && m_is_write));
        chk("mem_address", LINE_W'(mem_address), LINE_W'(m_addr));
        chk("mem_wdata",   mem_wdata, m_wdata);
        chk("i_resp", LINE_W'(i_resp), LINE_W'(!rst && mem_resp && m_busy && !m_owner_d));
        chk("d_resp", LINE_W'(d_resp), LINE_W'(!rst && mem_resp && m_busy && m_owner_d));
        chk("i_rdata", i_rdata, mem_rdata);
        chk("d_rdata", d_rdata, mem_rdata);
        chk("i_grants", LINE_W'(i_grants), LINE_W'(m_icnt));
        chk("d_grants", LINE_W'(d_grants), LINE_W'(m_dcnt));
    endtask

    // Advance one clock edge and apply the arbitration rules to the reference.
    task automatic tick();
        bit i_pend, d_pend, pick_d;
        i_pend = i_read;
        d_pend = d_read || d_write;
        @(posedge clk);
        if (rst) begin
            m_busy = 0; m_owner_d = 0; m_is_write = 0; m_addr = '0; m_wdata = '0;
            m_last_was_d = 0; m_icnt = '0; m_dcnt = '0;
        end else if (m_busy) begin
            if (mem_resp) m_busy = 0;
        end else if (i_pend || d_pend) begin
            pick_d = (i_pend && d_pend) ? !m_last_was_d : d_pend;
            m_busy = 1; m_owner_d = pick_d; m_last_was_d = pick_d;
            if (pick_d) begin
                m_is_write = d_write;
                m_addr = d_address;
                if (d_write) m_wdata = d_wdata;
                m_dcnt = m_dcnt + 1;
            end else begin
                m_is_write = 0;
                m_addr = i_address;
                m_icnt = m_icnt + 1;
            end
        end
    endtask

    task automatic step(input logic r, ir, dr, dw, mr, input logic [31:0] ia, da,
                        input logic [LINE_W-1:0] wd, rd);
        drive(r, ir, dr, dw, mr, ia, da, wd, rd);
        check_model();
        tick();
    endtask

    initial begin
        vec_t              vecs[$];
        logic [LINE_W-1:0] pat_a, pat_b, rnd;
        bit                order[$];
        bit                exp_order[6] = '{1, 0, 1, 0, 1, 0};

        pat_a = {8{32'hA5A5_0F0F}};
        pat_b = {8{32'h1234_5678}};
        rst = 1; i_read = 0; d_read = 0; d_write = 0; mem_resp = 0;
        i_address = '0; d_address = '0; d_wdata = '0; mem_rdata = '0;
        m_busy = 0; m_owner_d = 0; m_is_write = 0; m_addr = '0; m_wdata = '0;
        m_last_was_d = 0; m_icnt = '0; m_dcnt = '0;

        // rst ir dr dw mr  ia  da        mrd mwr iresp dresp addr
        vecs.push_back('{1, 0, 0, 0, 0, 32'h0,  32'h0,    0, 0, 0, 0, 32'h0});
        vecs.push_back('{0, 1, 0, 0, 0, 32'h60, 32'h0,    0, 0, 0, 0, 32'h0});
        vecs.push_back('{0, 0, 0, 0, 0, 32'h99, 32'h0,    1, 0, 0, 0, 32'h60});
        vecs.push_back('{0, 0, 0, 0, 1, 32'h99, 32'h0,    1, 0, 1, 0, 32'h60});
        vecs.push_back('{0, 0, 0, 0, 1, 32'h0,  32'h0,    0, 0, 0, 0, 32'h60});
        vecs.push_back('{0, 0, 1, 1, 0, 32'h0,  32'h2000, 0, 0, 0, 0, 32'h60});
        vecs.push_back('{0, 0, 0, 0, 0, 32'h0,  32'h3000, 0, 1, 0, 0, 32'h2000});
        vecs.push_back('{0, 0, 0, 0, 1, 32'h0,  32'h3000, 0, 1, 0, 1, 32'h2000});
        vecs.push_back('{0, 0, 0, 0, 0, 32'h0,  32'h0,    0, 0, 0, 0, 32'h2000});

        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].rst, vecs[k].ir, vecs[k].dr, vecs[k].dw, vecs[k].mr,
                  vecs[k].ia, vecs[k].da, pat_b, pat_a);
            check_model();
            chk($sformatf("vec%0d mem_read", k),    LINE_W'(mem_read),    LINE_W'(vecs[k].e_mrd));
            chk($sformatf("vec%0d mem_write", k),   LINE_W'(mem_write),   LINE_W'(vecs[k].e_mwr));
            chk($sformatf("vec%0d i_resp", k),      LINE_W'(i_resp),      LINE_W'(vecs[k].e_iresp));
            chk($sformatf("vec%0d d_resp", k),      LINE_W'(d_resp),      LINE_W'(vecs[k].e_dresp));
            chk($sformatf("vec%0d mem_address", k), LINE_W'(mem_address), LINE_W'(vecs[k].e_addr));
            if (vecs[k].e_iresp) chk("fill data", i_rdata, pat_a);
            tick();
        end
        chk("i_grants after table", LINE_W'(i_grants), LINE_W'(16'd1));
        chk("d_grants after table", LINE_W'(d_grants), LINE_W'(16'd1));

        // Sustained contention from reset: grants alternate starting with D.
        step(1, 0, 0, 0, 0, 0, 0, '0, '0);
        for (int t = 0; t < 6; t++) begin
            step(0, 1, 1, 0, 0, 32'h100, 32'h200, '0, pat_a);
            drive(0, 1, 1, 0, 0, 32'h100, 32'h200, '0, pat_a);
            check_model();
            order.push_back(mem_address == 32'h200);
            tick();
            step(0, 1, 1, 0, 1, 32'h100, 32'h200, '0, pat_a);
        end
        for (int t = 0; t < 6; t++) chk($sformatf("grant order %0d", t), LINE_W'(order[t]), LINE_W'(exp_order[t]));
        chk("alt i_grants", LINE_W'(i_grants), LINE_W'(16'd3));
        chk("alt d_grants", LINE_W'(d_grants), LINE_W'(16'd3));

        // Writeback with inputs changing after grant.
        step(0, 0, 0, 1, 0, 0, 32'h1000, pat_b, '0);
        for (int t = 0; t < 3; t++) begin
            drive(0, 0, t[0], ~t[0], 0, 0, 32'h5550 + 32'(t), pat_a, '0);
            check_model();
            chk("wb mem_write", LINE_W'(mem_write), LINE_W'(1'b1));
            chk("wb mem_address", LINE_W'(mem_address), LINE_W'(32'h1000));
            chk("wb mem_wdata", mem_wdata, pat_b);
            tick();
        end
        drive(0, 0, 0, 0, 1, 0, 32'h7, pat_a, '0);
        check_model();
        chk("wb d_resp", LINE_W'(d_resp), LINE_W'(1'b1));
        tick();
        drive(0, 0, 0, 0, 0, 0, 32'h7, pat_a, '0);
        check_model();
        chk("wb d_resp one cycle", LINE_W'(d_resp), LINE_W'(1'b0));
        tick();

        // Reset during a D fill, with a late adaptor response.
        step(0, 0, 1, 0, 0, 0, 32'h40, '0, '0);
        step(0, 0, 0, 0, 0, 0, 32'h40, '0, '0);
        drive(1, 0, 0, 0, 1, 0, 0, '0, pat_a);
        check_model();
        chk("rst d_resp", LINE_W'(d_resp), LINE_W'(1'b0));
        tick();
        drive(0, 0, 0, 0, 1, 0, 0, '0, pat_a);
        check_model();
        chk("post-rst mem_read", LINE_W'(mem_read), LINE_W'(1'b0));
        chk("post-rst d_resp", LINE_W'(d_resp), LINE_W'(1'b0));
        chk("post-rst counters", LINE_W'({i_grants, d_grants}), LINE_W'(32'h0));
        tick();

        // Random traffic against the reference.
        for (int t = 0; t < 1500; t++) begin
            rnd = {8{$urandom}};
            step(($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 2) == 0), {$urandom_range(0, 15), 4'h0}, {$urandom_range(16, 31), 4'h0},
                 rnd, ~rnd);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
